// File: rtl/multicycle_controller_if.sv
// Memory-port handshake between the multicycle controller (master) and the
// shared instruction/data memory (slave).
interface multicycle_controller_if;
  logic MemReq;
  logic MemWrite;
  logic AdrSrc;
  logic MemReady;

  modport master (output MemReq, MemWrite, AdrSrc, input MemReady);
  modport slave  (input MemReq, MemWrite, AdrSrc, output MemReady);
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing FSM with bounded memory wait and sticky traps.
// Define RV_LUI_AUIPC_EN to decode LUI/AUIPC through the EXECU state.
module multicycle_controller #(
  parameter int MAX_WAIT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              Opcode,
  input  logic [2:0]              Funct3,
  input  logic                    Zero,
  multicycle_controller_if.master mem,
  output logic                    IRWrite,
  output logic                    RegWrite,
  output logic                    PCWrite,
  output logic [1:0]              ALUSrcA,
  output logic [1:0]              ALUSrcB,
  output logic [1:0]              ResultSrc,
  output logic [1:0]              ALUOp,
  output logic [2:0]              ImmSrc,
  output logic                    Illegal,
  output logic                    BusErr
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
`ifdef RV_LUI_AUIPC_EN
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
`endif

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_EXECU, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2, S_TRAP
  } state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          illegal_q, buserr_q;
  logic          set_illegal, set_buserr;
  logic          timeout, br_ok;

  assign br_ok   = (Funct3 == 3'b000) || (Funct3 == 3'b001);
  // A request still unanswered after MAX_WAIT waiting cycles; a late MemReady wins.
  assign timeout = mem.MemReq && !mem.MemReady && (wait_q == WW'(MAX_WAIT));

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    set_illegal = 1'b0;
    set_buserr  = 1'b0;
    case (state_q)
      S_RESET:    state_d = S_FETCH;
      S_FETCH:    if (mem.MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR1;
`ifdef RV_LUI_AUIPC_EN
          OP_LUI, OP_AUIPC:  state_d = S_EXECU;
`endif
          default: begin
            state_d     = S_TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (Opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem.MemReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem.MemReady) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_EXECU: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH: begin
        if (br_ok) begin
          state_d = S_FETCH;
        end else begin
          state_d     = S_TRAP;
          set_illegal = 1'b1;
        end
      end
      S_JAL:      state_d = S_ALUWB;
      S_JALR1:    state_d = S_JALR2;
      S_JALR2:    state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_RESET;
    endcase
    if (timeout) begin
      state_d    = S_TRAP;
      set_buserr = 1'b1;
    end
    if (state_d != state_q || !mem.MemReq || mem.MemReady) wait_d = '0;
    else                                                  wait_d = wait_q + 1'b1;
  end

  // NOTE: the async reset clears state, wait counter and trap flags together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      buserr_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_q | set_illegal;
      buserr_q  <= buserr_q | set_buserr;
    end
  end

  always_comb begin
    mem.MemReq   = 1'b0;
    mem.MemWrite = 1'b0;
    mem.AdrSrc   = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    PCWrite      = 1'b0;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ResultSrc    = 2'b00;
    ALUOp        = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem.MemReq = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        IRWrite    = mem.MemReady;
        PCWrite    = mem.MemReady;
      end
      S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_MEMREAD:  begin mem.MemReq = 1'b1; mem.AdrSrc = 1'b1; end
      S_MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
      S_MEMWRITE: begin mem.MemReq = 1'b1; mem.MemWrite = 1'b1; mem.AdrSrc = 1'b1; end
      S_EXECR:    begin ALUSrcA = 2'b10; ALUOp = 2'b10; end
      S_EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUOp = 2'b10; end
`ifdef RV_LUI_AUIPC_EN
      S_EXECU: begin
        ALUSrcA = (Opcode == OP_LUI) ? 2'b11 : 2'b01;
        ALUSrcB = 2'b01;
      end
`endif
      S_ALUWB:    RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = br_ok && ((Funct3 == 3'b000) ? Zero : !Zero);
      end
      S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1; end
      S_JALR1:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_JALR2:    begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    case (Opcode)
      OP_STORE:         ImmSrc = 3'b001;
      OP_BR:            ImmSrc = 3'b010;
      OP_JAL:           ImmSrc = 3'b011;
`ifdef RV_LUI_AUIPC_EN
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
`endif
      default:          ImmSrc = 3'b000;
    endcase
  end

  assign Illegal = illegal_q;
  assign BusErr  = buserr_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: each instruction is expanded into a list of expected
// per-cycle control words, then replayed against the controller cycle by cycle.
module tb_multicycle_controller;
  localparam int MAX_WAIT = 4;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum int {K_R, K_I, K_LOAD, K_STORE, K_BEQ, K_BNE, K_JAL, K_JALR} kind_e;

  typedef struct {
    logic       rdy, zero;
    logic       mreq, mwr, adr, irw, regw, pcw;
    logic [1:0] asa, asb, rs, aop;
    logic       ill, bus;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] Opcode = 7'b0;
  logic [2:0] Funct3 = 3'b0;
  logic       Zero = 1'b0;
  logic       IRWrite, RegWrite, PCWrite, Illegal, BusErr;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
  logic [2:0] ImmSrc;

  multicycle_controller_if mem_bus ();

  multicycle_controller #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct3(Funct3), .Zero(Zero),
    .mem(mem_bus), .IRWrite(IRWrite), .RegWrite(RegWrite), .PCWrite(PCWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp),
    .ImmSrc(ImmSrc), .Illegal(Illegal), .BusErr(BusErr)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  cyc_t exp_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      OP_STORE: return 3'b001;
      OP_BR:    return 3'b010;
      OP_JAL:   return 3'b011;
`ifdef RV_LUI_AUIPC_EN
      OP_LUI, OP_AUIPC: return 3'b100;
`endif
      default:  return 3'b000;
    endcase
  endfunction

  function automatic bit legal(input logic [6:0] op);
`ifdef RV_LUI_AUIPC_EN
    if (op == OP_LUI || op == OP_AUIPC) return 1'b1;
`endif
    return op inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR};
  endfunction

  function automatic logic [6:0] op_of(input kind_e k);
    case (k)
      K_R:     return OP_R;
      K_I:     return OP_I;
      K_LOAD:  return OP_LOAD;
      K_STORE: return OP_STORE;
      K_BEQ, K_BNE: return OP_BR;
      K_JAL:   return OP_JAL;
      default: return OP_JALR;
    endcase
  endfunction

  function automatic logic [2:0] f3_of(input kind_e k);
    if (k == K_BEQ) return 3'b000;
    if (k == K_BNE) return 3'b001;
    return 3'($urandom);
  endfunction

  // A cycle with every strobe low; MemReady/Zero are don't-care noise here.
  function automatic cyc_t quiet();
    cyc_t c;
    c = '{default: '0};
    c.rdy  = 1'($urandom);
    c.zero = 1'($urandom);
    return c;
  endfunction

  // kind 0 = instruction fetch, 1 = data read, 2 = data write.
  task automatic push_req(input int kind, input int n_wait, input bit ready_last);
    cyc_t c;
    for (int i = 0; i < n_wait + (ready_last ? 1 : 0); i++) begin
      c      = quiet();
      c.rdy  = ready_last && (i == n_wait);
      c.mreq = 1'b1;
      if (kind == 0) begin
        c.asb = 2'b10;
        c.rs  = 2'b10;
        c.irw = c.rdy;
        c.pcw = c.rdy;
      end else begin
        c.adr = 1'b1;
        c.mwr = (kind == 2);
      end
      exp_q.push_back(c);
    end
  endtask

  task automatic push_step(input logic [1:0] asa, input logic [1:0] asb, input logic [1:0] aop,
                           input logic [1:0] rs, input logic regw, input logic pcw);
    cyc_t c;
    c = quiet();
    c.asa = asa; c.asb = asb; c.aop = aop; c.rs = rs; c.regw = regw; c.pcw = pcw;
    exp_q.push_back(c);
  endtask

  task automatic push_trap(input logic ill, input logic bus, input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = quiet();
      c.ill = ill;
      c.bus = bus;
      exp_q.push_back(c);
    end
  endtask

  task automatic build(input kind_e k, input int wf, input int wm);
    cyc_t c;
    push_req(0, wf, 1'b1);
    push_step(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    case (k)
      K_R: begin
        push_step(2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
        push_step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
      end
      K_I: begin
        push_step(2'b10, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0);
        push_step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
      end
      K_LOAD: begin
        push_step(2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        push_req(1, wm, 1'b1);
        push_step(2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
      end
      K_STORE: begin
        push_step(2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        push_req(2, wm, 1'b1);
      end
      K_BEQ, K_BNE: begin
        c     = quiet();
        c.asa = 2'b10;
        c.aop = 2'b01;
        c.pcw = (k == K_BEQ) ? c.zero : !c.zero;
        exp_q.push_back(c);
      end
      K_JAL: begin
        push_step(2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1);
        push_step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
      end
      default: begin
        push_step(2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        push_step(2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1);
        push_step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
      end
    endcase
  endtask

  task automatic compare(input cyc_t c);
    check("MemReq",    8'(mem_bus.MemReq),   8'(c.mreq));
    check("MemWrite",  8'(mem_bus.MemWrite), 8'(c.mwr));
    check("AdrSrc",    8'(mem_bus.AdrSrc),   8'(c.adr));
    check("IRWrite",   8'(IRWrite),          8'(c.irw));
    check("RegWrite",  8'(RegWrite),         8'(c.regw));
    check("PCWrite",   8'(PCWrite),          8'(c.pcw));
    check("ALUSrcA",   8'(ALUSrcA),          8'(c.asa));
    check("ALUSrcB",   8'(ALUSrcB),          8'(c.asb));
    check("ResultSrc", 8'(ResultSrc),        8'(c.rs));
    check("ALUOp",     8'(ALUOp),            8'(c.aop));
    check("ImmSrc",    8'(ImmSrc),           8'(imm_of(Opcode)));
    check("Illegal",   8'(Illegal),          8'(c.ill));
    check("BusErr",    8'(BusErr),           8'(c.bus));
  endtask

  // Replays the expected queue: drive on the falling edge, sample 1 time unit later.
  task automatic play(input logic [6:0] op, input logic [2:0] f3);
    cyc_t c;
    bit   first = 1'b1;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      @(negedge clk);
      if (first) begin
        Opcode = op;
        Funct3 = f3;
        first  = 1'b0;
      end
      mem_bus.MemReady = c.rdy;
      Zero             = c.zero;
      #1;
      compare(c);
    end
  endtask

  task automatic apply_reset();
    cyc_t c;
    c = '{default: '0};
    @(negedge clk);
    rst_n = 1'b0;
    mem_bus.MemReady = 1'b0;
    #1;
    compare(c);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare(c);
  endtask

  task automatic branch_case(input kind_e k, input logic z, input logic exp_pcw);
    cyc_t c;
    build(k, 0, 0);
    c = exp_q.pop_back();
    c.zero = z;
    c.pcw  = exp_pcw;
    exp_q.push_back(c);
    play(OP_BR, f3_of(k));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cpi_lit[8] = '{4, 4, 5, 4, 3, 3, 4, 5};
    kind_e k;
    logic [6:0] op;
    cyc_t c;

    mem_bus.MemReady = 1'b0;
    apply_reset();

    for (int i = 0; i < 8; i++) begin
      k = kind_e'(i);
      build(k, 0, 0);
      check($sformatf("cpi_%0d", i), 8'(exp_q.size()), 8'(cpi_lit[i]));
      play(op_of(k), f3_of(k));
    end

    build(K_LOAD, 0, 3);
    check("lw_3wait_len", 8'(exp_q.size()), 8'd8);
    play(OP_LOAD, 3'b010);

    build(K_R, MAX_WAIT, 0);
    check("fetch_late_ready_len", 8'(exp_q.size()), 8'd8);
    play(OP_R, 3'b000);

    branch_case(K_BEQ, 1'b1, 1'b1);
    branch_case(K_BNE, 1'b1, 1'b0);
    branch_case(K_BEQ, 1'b0, 1'b0);
    branch_case(K_BNE, 1'b0, 1'b1);

    // Fetch never acknowledged: bus-error trap after MAX_WAIT+1 cycles.
    push_req(0, MAX_WAIT + 1, 1'b0);
    push_trap(1'b0, 1'b1, 4);
    play(OP_R, 3'b000);
    apply_reset();

    push_req(0, 0, 1'b1);
    push_step(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    push_step(2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    push_req(1, MAX_WAIT + 1, 1'b0);
    push_trap(1'b0, 1'b1, 3);
    play(OP_LOAD, 3'b010);
    apply_reset();

    push_req(0, 1, 1'b1);
    push_step(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    push_step(2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    push_req(2, MAX_WAIT + 1, 1'b0);
    push_trap(1'b0, 1'b1, 3);
    play(OP_STORE, 3'b010);
    apply_reset();

`ifdef RV_LUI_AUIPC_EN
    push_req(0, 0, 1'b1);
    push_step(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    push_step(2'b11, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    push_step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    check("lui_len", 8'(exp_q.size()), 8'd4);
    play(OP_LUI, 3'b000);
    push_req(0, 0, 1'b1);
    push_step(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    push_step(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    push_step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    play(OP_AUIPC, 3'b000);
`else
    push_req(0, 0, 1'b1);
    push_step(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    push_trap(1'b1, 1'b0, 3);
    play(OP_LUI, 3'b000);
    apply_reset();
`endif

    // Branch with an unsupported funct3 traps without writing the PC.
    push_req(0, 0, 1'b1);
    push_step(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    push_step(2'b10, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
    push_trap(1'b1, 1'b0, 3);
    play(OP_BR, 3'($urandom_range(2, 7)));
    apply_reset();

    for (int i = 0; i < 6; i++) begin
      do op = 7'($urandom); while (legal(op));
      push_req(0, $urandom_range(0, MAX_WAIT), 1'b1);
      push_step(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
      push_trap(1'b1, 1'b0, 2);
      play(op, 3'($urandom));
      apply_reset();
    end

    // Reset pulsed in the middle of a stalled store.
    push_req(0, 0, 1'b1);
    push_step(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    push_step(2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    play(OP_STORE, 3'b010);
    @(negedge clk);
    mem_bus.MemReady = 1'b0;
    #1;
    check("mw_pre_req", 8'(mem_bus.MemReq), 8'd1);
    check("mw_pre_wr",  8'(mem_bus.MemWrite), 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mw_rst_req", 8'(mem_bus.MemReq), 8'd0);
    check("mw_rst_wr",  8'(mem_bus.MemWrite), 8'd0);
    check("mw_rst_adr", 8'(mem_bus.AdrSrc), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    c = '{default: '0};
    compare(c);
    build(K_R, 0, 0);
    play(OP_R, 3'b000);

    for (int i = 0; i < 200; i++) begin
      k = kind_e'($urandom_range(0, 7));
      build(k, $urandom_range(0, MAX_WAIT), $urandom_range(0, MAX_WAIT));
      play(op_of(k), f3_of(k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing control unit for the multicycle RV32I core: a Moore-style FSM that steps each instruction through fetch, decode, execute, memory and writeback over 3–5+ cycles. It also handles variable-latency memory with a ready handshake, a bounded wait timeout, illegal-opcode trapping, and `bne` in addition to `beq`. It sits between the instruction register and the shared datapath (single memory port, ALU, `ALUOut`/`Data`/`OldPC` registers); the existing ALU decoder consumes its `ALUOp`.

## Interface
- `MAX_WAIT`, 15: maximum consecutive cycles `MemReq` may stay un-acknowledged before a bus-error trap; ≥1.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `Opcode` in 7: `Instr[6:0]` from the instruction register.
- `Funct3` in 3: `Instr[14:12]`.
- `Zero` in 1: ALU zero flag.
- `MemReady` in 1: memory acknowledges the current request this cycle.
- `MemReq`, `MemWrite`, `AdrSrc`, `IRWrite`, `RegWrite`, `PCWrite` out 1: datapath strobes.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 rs1, 11 zero.
- `ALUSrcB` out 2: 00 rs2, 01 imm, 10 const 4.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `ALUOp` out 2: 00 add, 01 sub, 10 funct decode.
- `ImmSrc` out 3: 000 I, 001 S, 010 B, 011 J, 100 U. Combinational from `Opcode`; 000 for unknown opcodes.
- `Illegal`, `BusErr` out 1: sticky trap flags.

## Operation
- States: RESET, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, EXECU, ALUWB, BRANCH, JAL, JALR1, JALR2, TRAP.
- All outputs not listed for a state are 0.
- RESET: all outputs 0. Goes to FETCH unconditionally on the first clock after `rst_n` deasserts.
- FETCH: `MemReq`=1, `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ResultSrc`=10. `IRWrite`=`PCWrite`=`MemReady`. Stays in FETCH while `MemReady`=0; goes to DECODE when `MemReady`=1.
- DECODE: `ALUSrcA`=01, `ALUSrcB`=01 (branch target into ALUOut). Next state by opcode:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR1
  - anything else → TRAP with `Illegal`=1
- MEMADR: `ALUSrcA`=10, `ALUSrcB`=01. Next: MEMREAD for a load, MEMWRITE for a store. `Opcode` is held stable by the IR.
- MEMREAD: `MemReq`=1, `AdrSrc`=1. Waits for `MemReady`, then MEMWB.
- MEMWB: `ResultSrc`=01, `RegWrite`=1 → FETCH.
- MEMWRITE: `MemReq`=`MemWrite`=1, `AdrSrc`=1. Held until `MemReady`, then FETCH.
- EXECR: `ALUSrcA`=10, `ALUOp`=10 → ALUWB.
- EXECI: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=10 → ALUWB.
- ALUWB: `RegWrite`=1 → FETCH.
- BRANCH: `ALUSrcA`=10, `ALUOp`=01. `PCWrite` = taken, where taken = `Zero` for `Funct3`=000 and `!Zero` for 001. Other `Funct3` values → TRAP with `Illegal`=1 (no PC write). Otherwise → FETCH.
- JAL: `ALUSrcA`=01, `ALUSrcB`=10, `PCWrite`=1 (PC←ALUOut target, ALUOut←OldPC+4) → ALUWB.
- JALR1: `ALUSrcA`=10, `ALUSrcB`=01 (ALUOut←rs1+imm; the datapath clears bit 0) → JALR2.
- JALR2: `PCWrite`=1, `ALUSrcA`=01, `ALUSrcB`=10 → ALUWB.
- Wait counter:
  - Width is $clog2(`MAX_WAIT`+1).
  - Increments each cycle `MemReq`=1 and `MemReady`=0; clears on `MemReady` and on any state change.
  - When the counter equals `MAX_WAIT` and `MemReady`=0, go to TRAP with `BusErr`=1.
  - `MemReady` arriving in that same cycle wins: normal transition, no trap.
- TRAP: all strobes 0. Holds until reset; `Illegal`/`BusErr` stay asserted.
- Asynchronous reset mid-instruction: state goes to RESET, the counter and flags clear, all outputs drop to 0 immediately. No partial write completes after `rst_n` falls.

## Timing
- Cycles per instruction with zero-wait memory (`MemReady` high in the first request cycle):
  - R/I-type: 4
  - load: 5
  - store: 4
  - branch: 3
  - jal: 4
  - jalr: 5
- Each wait cycle on a request adds 1 cycle.
- State register updates on the rising `clk` edge.
- Outputs depend combinationally on state, `Opcode` (for `ImmSrc`), `MemReady`, `Zero` and `Funct3` only; no input-to-state combinational loops.
- `MemReq` and `MemWrite` stay stable from assertion until the cycle `MemReady` is sampled high.

## Configuration
- `RV_LUI_AUIPC_EN` defined:
  - DECODE sends 0110111 (LUI) and 0010111 (AUIPC) to EXECU.
  - EXECU: `ALUSrcA`=11 for LUI or 01 for AUIPC, `ALUSrcB`=01, `ALUOp`=00 → ALUWB. Both take 4 cycles.
  - `ImmSrc`=100 for these opcodes.
- Undefined: those opcodes take the TRAP path with `Illegal`=1; EXECU is unreachable and may be omitted.

## Test plan
- Reset then `add` (0110011), `MemReady` tied 1 → RESET, FETCH, DECODE, EXECR, ALUWB. `RegWrite`=1 only in cycle 4; `PCWrite`=`IRWrite`=1 only in FETCH.
- `lw` with `MemReady` low for 3 cycles in MEMREAD → MEMREAD lasts 4 cycles with `MemReq`=1, `AdrSrc`=1 throughout; 8 cycles total; then MEMWB with `ResultSrc`=01.
- `beq`/`bne` (`Funct3` 000/001) with `Zero`=1 → `PCWrite`=1 for beq and 0 for bne in BRANCH; `Zero`=0 gives the inverse.
- `MAX_WAIT`=4, `MemReady` never asserted in FETCH → TRAP after 5 cycles, `BusErr`=1 sticky. With `MemReady` in the 5th cycle → DECODE, no trap.
- Opcode 0110111 → with `RV_LUI_AUIPC_EN`: EXECU with `ALUSrcA`=11, `ImmSrc`=100. Without it: TRAP, `Illegal`=1.
- `rst_n` pulsed low during MEMWRITE → `MemWrite`/`MemReq` drop in the same cycle; after release, RESET then FETCH.
